// File: rtl/ifu_pkg.sv
// Shared encodings and defaults for the instruction fetch unit.
package ifu_pkg;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_BR  = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_sel_t;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

  // Word offset of a branch: sign-extended imm16 scaled to bytes.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/ifu_npc.sv
// Next-PC target calculation for control transfers resolved in ID.
module ifu_npc
  import ifu_pkg::*;
(
  input  logic [1:0]  npc_sel,
  input  logic [31:0] id_pc4,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] jr_target,
  output logic [31:0] target
);

  always_comb begin
    // NOTE: default first so every path assigns target and no latch is inferred.
    target = id_pc4;
    case (npc_sel_t'(npc_sel))
      NPC_BR:  target = id_pc4 + branch_offset(imm16);
      NPC_J:   target = {id_pc4[31:28], instr_index, 2'b00};
      NPC_JR:  target = jr_target;
      default: target = id_pc4;
    endcase
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: PC register, IF/ID pipeline register, redirect/stall control.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [1:0]  npc_sel,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] jr_target,
  output logic [11:0] im_addr,
  input  logic [31:0] im_dout,
  output logic [31:0] pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic        id_valid,
  output logic        misalign
);

  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        flush;
  logic        advance;

  ifu_npc npc (
    .npc_sel     (npc_sel),
    .id_pc4      (id_pc4),
    .imm16       (imm16),
    .instr_index (instr_index),
    .jr_target   (jr_target),
    .target      (target)
  );

  assign im_addr  = pc[11:0];
  assign pc_plus4 = pc + 32'd4;
  assign flush    = redirect && (npc_sel_t'(npc_sel) != NPC_SEQ);
  // A sequential-kind redirect overrides stall just like a taken one.
  assign advance  = !stall || redirect;

  // NOTE: non-blocking assignments here so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    misalign <= 1'b0;
    if (rst) begin
      pc       <= RESET_PC;
      id_instr <= NOP_INSTR;
      id_pc    <= '0;
      id_pc4   <= '0;
      id_valid <= 1'b0;
    end else if (flush) begin
      pc       <= {target[31:2], 2'b00};
      id_instr <= NOP_INSTR;
      id_pc    <= pc;
      id_pc4   <= pc_plus4;
      id_valid <= 1'b0;
      misalign <= |target[1:0];
    end else if (advance) begin
      pc       <= pc_plus4;
      id_instr <= im_dout;
      id_pc    <= pc;
      id_pc4   <= pc_plus4;
      id_valid <= 1'b1;
    end
  end

endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000, instruction word injected on flush/reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 stall  input  1  hazard hold request from decode.
REQ-006 redirect  input  1  taken control transfer resolved in ID this cycle.
REQ-007 npc_sel  input  2  target kind: 00 seq, 01 branch, 10 j/jal, 11 jr.
REQ-008 imm16  input  16  branch offset field of the ID-stage instruction.
REQ-009 instr_index  input  26  j/jal target field of the ID-stage instruction.
REQ-010 jr_target  input  32  register value for jr.
REQ-011 im_addr  output  12  byte address to instruction memory, equal to pc[11:0].
REQ-012 im_dout  input  32  instruction word returned combinationally by instruction memory.
REQ-013 pc  output  32  current IF-stage PC.
REQ-014 id_instr  output  32  IF/ID registered instruction.
REQ-015 id_pc  output  32  IF/ID registered PC of id_instr.
REQ-016 id_pc4  output  32  IF/ID registered id_pc+4 (jal link value).
REQ-017 id_valid  output  1  id_instr is a real fetched instruction, not a bubble.
REQ-018 misalign  output  1  one-cycle pulse: redirect target had bits[1:0] nonzero.

Function
REQ-019 Target calc: branch = id_pc4 + (sign-extended imm16 << 2); j = {id_pc4[31:28], instr_index, 2'b00}; jr = jr_target; all arithmetic mod 2^32.
REQ-020 Priority per edge: rst > redirect > stall > sequential.
REQ-021 Sequential (no rst/redirect/stall): pc <= pc+4; IF/ID <= {im_dout, pc, pc+4}, id_valid <= 1.
REQ-022 Stall without redirect: pc, id_instr, id_pc, id_pc4, id_valid all hold.
REQ-023 Redirect with npc_sel != 00: pc <= target with bits[1:0] forced to 00; IF/ID <= {NOP_INSTR, pc, pc+4}, id_valid <= 0 (wrong-path fetch squashed, single bubble).
REQ-024 Redirect with npc_sel == 00 behaves as sequential (REQ-021); no flush.
REQ-025 Redirect and stall same cycle: redirect wins, stall ignored.
REQ-026 misalign asserts on the edge following a redirect whose raw target[1:0] != 00, for exactly one cycle; deasserts otherwise.
REQ-027 Latency: instruction at address A appears on id_instr one edge after pc == A with no stall/redirect.
REQ-028 Address wrap: im_addr = pc[11:0]; pc itself does not wrap at 4 KB; pc+4 wraps naturally at 2^32.
REQ-029 No delay slot: instruction after a taken transfer is always squashed.

Reset
REQ-030 On rst edge: pc <= RESET_PC, id_instr <= NOP_INSTR, id_pc <= 0, id_pc4 <= 0, id_valid <= 0, misalign <= 0.
REQ-031 rst mid-stall or mid-redirect discards the pending transfer; first fetch after rst deasserts is RESET_PC.

Structure
REQ-032 Shared package ifu_pkg holds NPC_SEQ/NPC_BR/NPC_J/NPC_JR encodings, RESET_PC default and NOP_INSTR default.
REQ-033 One combinational sub-module npc computes the target from npc_sel, id_pc4, imm16, instr_index, jr_target.
REQ-034 im_addr driven directly from pc register bits; no combinational path from im_dout to im_addr.

Verification
REQ-035 Reset then 3 free cycles with im_dout=addr-tagged words -> pc 3000,3004,3008,300C; id_pc 3000,3004,3008, id_valid 0 then 1.
REQ-036 Branch redirect, id_pc4=3008, imm16=16'hFFFE -> pc=3000 next edge, id_instr=0, id_valid=0.
REQ-037 j with id_pc4=3010, instr_index=26'h0000C10 -> pc=0000_3040; jr with jr_target=3103 -> pc=3100, misalign pulses 1 cycle.
REQ-038 stall held 2 cycles at pc=3008 -> pc and IF/ID unchanged both cycles, resume with pc=300C.
REQ-039 stall and redirect (jr_target=3200) same cycle -> pc=3200, IF/ID flushed.
REQ-040 rst asserted same cycle as redirect -> pc=RESET_PC, id_valid=0, misalign=0.
